// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receiver timing blocks.
package uart_rx_pkg;

   // Smallest oversampling ratio that leaves room for mid-1 .. mid+1 inside a bit.
   localparam int unsigned MIN_PRESCALE = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_ERR  = 2'd2
   } state_e;

endpackage : uart_rx_pkg

// File: rtl/uart_rx_bit_timer_if.sv
// Control/status bundle between the RX FSM (master) and the bit timer (slave).
interface uart_rx_bit_timer_if #(
   parameter int unsigned PRESCALE_W = 6,
   parameter int unsigned BIT_CNT_W  = 4
);
   logic                  enable;
   logic [PRESCALE_W-1:0] prescale;
   logic [BIT_CNT_W-1:0]  frame_bits;
   logic [PRESCALE_W-1:0] edge_cnt;
   logic [BIT_CNT_W-1:0]  bit_cnt;
   logic                  sample_stb;
   logic                  sample_last;
   logic                  bit_done;
   logic                  frame_done;
   logic                  cfg_err;

   modport master (
      output enable, prescale, frame_bits,
      input  edge_cnt, bit_cnt, sample_stb, sample_last, bit_done, frame_done, cfg_err
   );

   modport slave (
      input  enable, prescale, frame_bits,
      output edge_cnt, bit_cnt, sample_stb, sample_last, bit_done, frame_done, cfg_err
   );
endinterface : uart_rx_bit_timer_if

// File: rtl/uart_rx_bit_timer.sv
// Edge/bit timing generator for the UART receiver.
// Optional build macro: UART_RX_TRIPLE_SAMPLE_EN (three samples per bit around mid).
// All outputs are registered; strobes are decoded from the next-state values so they
// line up with the counter values they describe.
module uart_rx_bit_timer
   import uart_rx_pkg::*;
#(
   parameter int unsigned PRESCALE_W = 6,
   parameter int unsigned BIT_CNT_W  = 4
) (
   input logic                 CLK,
   input logic                 RST,
   uart_rx_bit_timer_if.slave  bus_if
);

   state_e                state_q, state_d;
   logic [PRESCALE_W-1:0] ps_q, ps_d;
   logic [BIT_CNT_W-1:0]  fb_q, fb_d;
   logic [PRESCALE_W-1:0] edge_q, edge_d;
   logic [BIT_CNT_W-1:0]  bit_q, bit_d;
   logic [PRESCALE_W-1:0] mid_d;
   logic                  stb_q, stb_d;
   logic                  last_q, last_d;
   logic                  bd_q, bd_d;
   logic                  fd_q, fd_d;
   logic                  err_q, err_d;

   // State, configuration latch, counters and registered strobes.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= ST_IDLE;
         ps_q    <= '0;
         fb_q    <= '0;
         edge_q  <= '0;
         bit_q   <= '0;
         stb_q   <= 1'b0;
         last_q  <= 1'b0;
         bd_q    <= 1'b0;
         fd_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ps_q    <= ps_d;
         fb_q    <= fb_d;
         edge_q  <= edge_d;
         bit_q   <= bit_d;
         stb_q   <= stb_d;
         last_q  <= last_d;
         bd_q    <= bd_d;
         fd_q    <= fd_d;
         err_q   <= err_d;
      end
   end

   // Next state, counter advance and strobe decode of the next-cycle values.
   always_comb begin
      state_d = state_q;
      ps_d    = ps_q;
      fb_d    = fb_q;
      edge_d  = '0;
      bit_d   = '0;
      mid_d   = '0;
      stb_d   = 1'b0;
      last_d  = 1'b0;
      bd_d    = 1'b0;
      fd_d    = 1'b0;
      err_d   = 1'b0;

      if (!bus_if.enable) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               ps_d = bus_if.prescale;
               fb_d = bus_if.frame_bits;
               if ((bus_if.prescale >= PRESCALE_W'(MIN_PRESCALE)) && (bus_if.frame_bits != '0)) begin
                  state_d = ST_RUN;
               end else begin
                  state_d = ST_ERR;
               end
            end
            ST_RUN: begin
               if (edge_q == ps_q - PRESCALE_W'(1)) begin
                  edge_d = '0;
                  bit_d  = (bit_q == fb_q - BIT_CNT_W'(1)) ? '0 : bit_q + BIT_CNT_W'(1);
               end else begin
                  edge_d = edge_q + PRESCALE_W'(1);
                  bit_d  = bit_q;
               end
            end
            ST_ERR: begin
               state_d = ST_ERR;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      if (state_d == ST_RUN) begin
         mid_d = ps_d >> 1;
         bd_d  = (edge_d == ps_d - PRESCALE_W'(1));
         fd_d  = bd_d && (bit_d == fb_d - BIT_CNT_W'(1));
`ifdef UART_RX_TRIPLE_SAMPLE_EN
         stb_d  = (edge_d >= mid_d - PRESCALE_W'(1)) && (edge_d <= mid_d + PRESCALE_W'(1));
         last_d = (edge_d == mid_d + PRESCALE_W'(1));
`else
         stb_d  = (edge_d == mid_d);
         last_d = (edge_d == mid_d);
`endif
      end

      err_d = (state_d == ST_ERR);
   end

   assign bus_if.edge_cnt    = edge_q;
   assign bus_if.bit_cnt     = bit_q;
   assign bus_if.sample_stb  = stb_q;
   assign bus_if.sample_last = last_q;
   assign bus_if.bit_done    = bd_q;
   assign bus_if.frame_done  = fd_q;
   assign bus_if.cfg_err     = err_q;

endmodule : uart_rx_bit_timer

// File: tb/tb_uart_rx_bit_timer.sv
// Self-checking bench for uart_rx_bit_timer: directed table, corner sequences and
// randomized traffic against a frame-arithmetic reference model.
module tb_uart_rx_bit_timer;

   localparam int unsigned PW = 6;
   localparam int unsigned BW = 4;

   logic CLK = 1'b0;
   logic RST;
   int   errors = 0;
   int   checks = 0;

   always #5 CLK = ~CLK;

   uart_rx_bit_timer_if #(.PRESCALE_W(PW), .BIT_CNT_W(BW)) bus_if ();

   uart_rx_bit_timer #(.PRESCALE_W(PW), .BIT_CNT_W(BW)) dut (
      .CLK    (CLK),
      .RST    (RST),
      .bus_if (bus_if)
   );

   // Reference model: position inside the run is a single cycle count.
   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_ERR  = 2;
   int m_mode, m_t, m_ps, m_fb;

   task automatic model_reset();
      m_mode = M_IDLE; m_t = 0; m_ps = 0; m_fb = 0;
   endtask

   task automatic model_clock(input logic en, input int ps, input int fb);
      if (!en) begin
         m_mode = M_IDLE; m_t = 0;
      end else if (m_mode == M_IDLE) begin
         m_ps = ps; m_fb = fb; m_t = 0;
         m_mode = (ps >= 4 && fb != 0) ? M_RUN : M_ERR;
      end else if (m_mode == M_RUN) begin
         m_t++;
      end
   endtask

   function automatic logic [14:0] model_out();
      int e, b, mid;
      logic s, l, bd, fd;
      if (m_mode != M_RUN) return {14'd0, (m_mode == M_ERR)};
      e   = m_t % m_ps;
      b   = (m_t / m_ps) % m_fb;
      mid = m_ps / 2;
      bd  = (e == m_ps - 1);
      fd  = bd && (b == m_fb - 1);
`ifdef UART_RX_TRIPLE_SAMPLE_EN
      s = (e >= mid - 1) && (e <= mid + 1);
      l = (e == mid + 1);
`else
      s = (e == mid);
      l = (e == mid);
`endif
      return {PW'(e), BW'(b), s, l, bd, fd, 1'b0};
   endfunction

   function automatic logic [14:0] dut_vec();
      return {bus_if.edge_cnt, bus_if.bit_cnt, bus_if.sample_stb, bus_if.sample_last,
              bus_if.bit_done, bus_if.frame_done, bus_if.cfg_err};
   endfunction

   task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // One clock with the given inputs, then compare against the model.
   task automatic step(input logic en, input int ps, input int fb, input string name);
      bus_if.enable     = en;
      bus_if.prescale   = PW'(ps);
      bus_if.frame_bits = BW'(fb);
      @(posedge CLK);
      model_clock(en, ps, fb);
      #1;
      check(name, dut_vec(), model_out());
   endtask

   typedef struct {
      logic          en;
      logic [PW-1:0] ps;
      logic [BW-1:0] fb;
      logic [PW-1:0] e;
      logic [BW-1:0] b;
      logic          s1, l1, s3, l3, bd, fd, err;
   } vec_t;

   vec_t vec [20];

   initial begin
      int bd_cnt, fd_cycle;
      bit found;
      logic [14:0] exp_v;

      // en ps fb | edge bit | s1 l1 s3 l3 bd fd err
      vec[0]  = '{1'b1, 6'd4,  4'd2, 6'd0, 4'd0, 0, 0, 0, 0, 0, 0, 0};
      vec[1]  = '{1'b1, 6'd4,  4'd2, 6'd1, 4'd0, 0, 0, 1, 0, 0, 0, 0};
      vec[2]  = '{1'b1, 6'd4,  4'd2, 6'd2, 4'd0, 1, 1, 1, 0, 0, 0, 0};
      vec[3]  = '{1'b1, 6'd4,  4'd2, 6'd3, 4'd0, 0, 0, 1, 1, 1, 0, 0};
      vec[4]  = '{1'b1, 6'd4,  4'd2, 6'd0, 4'd1, 0, 0, 0, 0, 0, 0, 0};
      vec[5]  = '{1'b1, 6'd4,  4'd2, 6'd1, 4'd1, 0, 0, 1, 0, 0, 0, 0};
      vec[6]  = '{1'b1, 6'd4,  4'd2, 6'd2, 4'd1, 1, 1, 1, 0, 0, 0, 0};
      vec[7]  = '{1'b1, 6'd4,  4'd2, 6'd3, 4'd1, 0, 0, 1, 1, 1, 1, 0};
      vec[8]  = '{1'b1, 6'd4,  4'd2, 6'd0, 4'd0, 0, 0, 0, 0, 0, 0, 0};
      vec[9]  = '{1'b0, 6'd4,  4'd2, 6'd0, 4'd0, 0, 0, 0, 0, 0, 0, 0};
      vec[10] = '{1'b1, 6'd3,  4'd2, 6'd0, 4'd0, 0, 0, 0, 0, 0, 0, 1};
      vec[11] = '{1'b1, 6'd9,  4'd2, 6'd0, 4'd0, 0, 0, 0, 0, 0, 0, 1};
      vec[12] = '{1'b0, 6'd9,  4'd2, 6'd0, 4'd0, 0, 0, 0, 0, 0, 0, 0};
      vec[13] = '{1'b1, 6'd5,  4'd0, 6'd0, 4'd0, 0, 0, 0, 0, 0, 0, 1};
      vec[14] = '{1'b0, 6'd5,  4'd0, 6'd0, 4'd0, 0, 0, 0, 0, 0, 0, 0};
      vec[15] = '{1'b1, 6'd4,  4'd1, 6'd0, 4'd0, 0, 0, 0, 0, 0, 0, 0};
      vec[16] = '{1'b1, 6'd20, 4'd7, 6'd1, 4'd0, 0, 0, 1, 0, 0, 0, 0};
      vec[17] = '{1'b1, 6'd20, 4'd7, 6'd2, 4'd0, 1, 1, 1, 0, 0, 0, 0};
      vec[18] = '{1'b1, 6'd20, 4'd7, 6'd3, 4'd0, 0, 0, 1, 1, 1, 1, 0};
      vec[19] = '{1'b1, 6'd20, 4'd7, 6'd0, 4'd0, 0, 0, 0, 0, 0, 0, 0};

      RST = 1'b1;
      bus_if.enable = 1'b0; bus_if.prescale = '0; bus_if.frame_bits = '0;
      model_reset();
      repeat (2) @(posedge CLK);
      #1;
      check("reset", dut_vec(), 15'd0);
      RST = 1'b0;
      step(1'b0, 0, 0, "idle_after_reset");

      // Directed table: small frames, wrap, config errors, live input changes.
      foreach (vec[i]) begin
         bus_if.enable     = vec[i].en;
         bus_if.prescale   = vec[i].ps;
         bus_if.frame_bits = vec[i].fb;
         @(posedge CLK);
         model_clock(vec[i].en, int'(vec[i].ps), int'(vec[i].fb));
         #1;
`ifdef UART_RX_TRIPLE_SAMPLE_EN
         exp_v = {vec[i].e, vec[i].b, vec[i].s3, vec[i].l3, vec[i].bd, vec[i].fd, vec[i].err};
`else
         exp_v = {vec[i].e, vec[i].b, vec[i].s1, vec[i].l1, vec[i].bd, vec[i].fd, vec[i].err};
`endif
         check($sformatf("table[%0d]", i), dut_vec(), exp_v);
      end

      // Nominal 8x10 frame: ten bit_done pulses, frame_done in RUN cycle 79, wrap at 80.
      step(1'b0, 8, 10, "nom_idle");
      step(1'b1, 8, 10, "nom_c0");
      bd_cnt = 0; fd_cycle = -1;
      for (int c = 0; c < 80; c++) begin
         if (c > 0) step(1'b1, 8, 10, "nominal");
         if (bus_if.bit_done) begin
            bd_cnt++;
            check_int("nom_bd_edge", int'(bus_if.edge_cnt), 7);
         end
         if (bus_if.frame_done) fd_cycle = c;
      end
      check_int("nom_bd_count", bd_cnt, 10);
      check_int("nom_fd_cycle", fd_cycle, 79);
      step(1'b1, 8, 10, "nom_c80");
      check_int("nom_wrap_bit", int'(bus_if.bit_cnt), 0);

      // Enable drop on the frame_done cycle.
      found = 1'b0;
      for (int k = 0; k < 200 && !found; k++) begin
         step(1'b1, 8, 10, "to_fd");
         if (bus_if.frame_done) found = 1'b1;
      end
      check_int("fd_seen", int'(found), 1);
      step(1'b0, 8, 10, "drop_on_fd");
      check("drop_on_fd_zero", dut_vec(), 15'd0);
      step(1'b0, 8, 10, "drop_idle");

      // Live config change mid-frame has no effect until the next IDLE->RUN.
      step(1'b1, 8, 10, "live_c0");
      for (int c = 1; c < 12; c++) begin
         step(1'b1, 16, 10, "live_ignored");
         if (c == 7) check_int("live_bd_at7", int'(bus_if.bit_done), 1);
      end
      step(1'b0, 16, 10, "live_drop");
      step(1'b1, 16, 10, "live_relatch");
      for (int c = 1; c < 20; c++) begin
         step(1'b1, 16, 10, "live_p16");
         if (c == 15) check_int("live_bd_at15", int'(bus_if.bit_done), 1);
      end

      // Odd prescale.
      step(1'b0, 9, 3, "odd_idle");
      for (int c = 0; c < 30; c++) step(1'b1, 9, 3, "odd_p9");

      // Asynchronous reset mid-run, then restart.
      step(1'b0, 8, 10, "rst_idle");
      for (int c = 0; c < 20; c++) step(1'b1, 8, 10, "pre_rst");
      #2 RST = 1'b1;
      #1;
      check("async_rst", dut_vec(), 15'd0);
      model_reset();
      @(posedge CLK);
      #1;
      check("rst_held", dut_vec(), 15'd0);
      RST = 1'b0;
      for (int c = 0; c < 12; c++) step(1'b1, 8, 10, "after_rst");

      // Randomized traffic.
      for (int c = 0; c < 3000; c++) begin
         logic en;
         int ps, fb;
         en = ($urandom_range(0, 99) < 97);
         ps = ($urandom_range(0, 9) == 0) ? $urandom_range(56, 63) : $urandom_range(2, 12);
         fb = $urandom_range(0, 15);
         step(en, ps, fb, "random");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_uart_rx_bit_timer
